// File: rtl/scan_front.sv
// Pad-side serial scan front end: synchronises the scan pads, shifts a 65-bit {we, addr, wrdata} frame and commits it on a load strobe.
// Build option SCAN_FRONT_PARITY_EN appends a trailing even-parity bit to the frame (66 bits).
module scan_front (
    input  logic        clk,
    input  logic        rstn,
    input  logic        scan_clk,
    input  logic        scan_in,
    input  logic        scan_load,
    input  logic [31:0] rddata,
    input  logic        rdvalid,
    output logic        scan_out,
    output logic [31:0] addr_scan,
    output logic [31:0] wrdata_scan,
    output logic        we_scan,
    output logic        sm_start_scan,
    output logic        scanxfer_scan,
    output logic        frame_err
);

`ifdef SCAN_FRONT_PARITY_EN
    localparam int SR_W    = 66;
    localparam int PAY_LSB = 1;
`else
    localparam int SR_W    = 65;
    localparam int PAY_LSB = 0;
`endif
    localparam logic [6:0] FRAME_LEN = 7'(SR_W);

    logic            r_sclk_meta, r_sclk_sync, r_sclk_hist;
    logic            r_load_meta, r_load_sync, r_load_hist;
    logic [2:0]      r_arm;
    logic [SR_W-1:0] r_sr;
    logic [6:0]      r_bit_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wrdata;
    logic            r_we;
    logic            r_start;
    logic            r_xfer;
    logic            r_err;

    logic            w_shift_edge;
    logic            w_load_edge;
    logic            w_frame_ok;

    // Edges are only honoured once the history flop holds a synchronised pad
    // value, so a pad already high at reset release never looks like a rise.
    assign w_shift_edge = r_sclk_sync & ~r_sclk_hist & r_arm[2];
    assign w_load_edge  = r_load_sync & ~r_load_hist & r_arm[2];

`ifdef SCAN_FRONT_PARITY_EN
    assign w_frame_ok = (r_bit_cnt == FRAME_LEN) && !(^r_sr);
`else
    assign w_frame_ok = (r_bit_cnt == FRAME_LEN);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_hist <= 1'b0;
            r_load_meta <= 1'b0;
            r_load_sync <= 1'b0;
            r_load_hist <= 1'b0;
            r_arm       <= '0;
        end else begin
            r_sclk_meta <= scan_clk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_hist <= r_sclk_sync;
            r_load_meta <= scan_load;
            r_load_sync <= r_load_meta;
            r_load_hist <= r_load_sync;
            r_arm       <= {r_arm[1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_addr    <= '0;
            r_wrdata  <= '0;
            r_we      <= 1'b0;
            r_start   <= 1'b0;
            r_xfer    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_err   <= 1'b0;
            // A load edge wins over a coincident shift edge, which is dropped.
            if (w_load_edge) begin
                r_bit_cnt <= '0;
                r_xfer    <= 1'b0;
                if (w_frame_ok) begin
                    r_we     <= r_sr[SR_W-1];
                    r_addr   <= r_sr[PAY_LSB+32 +: 32];
                    r_wrdata <= r_sr[PAY_LSB +: 32];
                    r_start  <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_shift_edge) begin
                r_sr   <= {r_sr[SR_W-2:0], scan_in};
                r_xfer <= 1'b1;
                if (r_bit_cnt != 7'd127) begin
                    r_bit_cnt <= r_bit_cnt + 7'd1;
                end
            end else if (rdvalid && !r_xfer) begin
                // Readback lands in the wrdata slot so it leaves scan_out after 33 shifts.
                r_sr[PAY_LSB +: 32] <= rddata;
            end
        end
    end

    assign scan_out      = r_sr[SR_W-1];
    assign addr_scan     = r_addr;
    assign wrdata_scan   = r_wrdata;
    assign we_scan       = r_we;
    assign sm_start_scan = r_start;
    assign scanxfer_scan = r_xfer;
    assign frame_err     = r_err;

endmodule

// File: tb/tb_scan_front.sv
// Self-checking bench for scan_front: table of frames plus hand sequences, pulses checked against a scoreboard queue.
module tb_scan_front;
`ifdef SCAN_FRONT_PARITY_EN
    localparam int FL  = 66;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = 65;
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        scan_clk = 1'b0;
    logic        scan_in = 1'b0;
    logic        scan_load = 1'b0;
    logic [31:0] rddata = '0;
    logic        rdvalid = 1'b0;
    logic        scan_out;
    logic [31:0] addr_scan;
    logic [31:0] wrdata_scan;
    logic        we_scan;
    logic        sm_start_scan;
    logic        scanxfer_scan;
    logic        frame_err;

    scan_front dut (
        .clk(clk), .rstn(rstn), .scan_clk(scan_clk), .scan_in(scan_in),
        .scan_load(scan_load), .rddata(rddata), .rdvalid(rdvalid),
        .scan_out(scan_out), .addr_scan(addr_scan), .wrdata_scan(wrdata_scan),
        .we_scan(we_scan), .sm_start_scan(sm_start_scan),
        .scanxfer_scan(scanxfer_scan), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [31:0] wrdata;
        logic        we;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wrdata;
        int          nbits;
        bit          flip;
        bit          exp_start;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wrdata = '0;
    logic        m_we = 1'b0;
    logic        prev_start = 1'b0;
    logic        prev_err = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Pulse monitor: every start/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn && (sm_start_scan || frame_err)) begin
            check("pulse_exclusive", {63'b0, sm_start_scan & frame_err}, 64'd0);
            check("pulse_width", {63'b0, (sm_start_scan & prev_start) | (frame_err & prev_err)}, 64'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {62'b0, sm_start_scan, frame_err}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", {62'b0, sm_start_scan, frame_err}, mon_e.is_err ? 64'd1 : 64'd2);
                check("addr_scan", {32'b0, addr_scan}, {32'b0, mon_e.addr});
                check("wrdata_scan", {32'b0, wrdata_scan}, {32'b0, mon_e.wrdata});
                check("we_scan", {63'b0, we_scan}, {63'b0, mon_e.we});
                check("scanxfer_at_pulse", {63'b0, scanxfer_scan}, 64'd0);
                $display("pulse %s addr=0x%08h wrdata=0x%08h we=%0d",
                         frame_err ? "err" : "start", addr_scan, wrdata_scan, we_scan);
            end
        end
        prev_start <= sm_start_scan;
        prev_err   <= frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pad_shift(input logic b);
        scan_in  = b;
        scan_clk = 1'b1;
        tick(4);
        scan_clk = 1'b0;
        tick(4);
    endtask

    task automatic pad_load();
        scan_load = 1'b1;
        tick(4);
        scan_load = 1'b0;
        tick(4);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    function automatic logic [65:0] make_frame(input logic we, input logic [31:0] a,
                                               input logic [31:0] d, input bit flip);
        logic [65:0] f;
        if (PAR) f = {we, a, d, (^{we, a, d}) ^ flip};
        else     f = {1'b0, we, a, d};
        return f;
    endfunction

    task automatic shift_frame(input logic [65:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            pad_shift(i < FL ? f[FL-1-i] : 1'b0);
        end
    endtask

    task automatic push_start(input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.wrdata = d; e.we = we;
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.addr = m_addr; e.wrdata = m_wrdata; e.we = m_we;
        sb_q.push_back(e);
    endtask

    task automatic check_held(input string name);
        check({name, "_addr"}, {32'b0, addr_scan}, {32'b0, m_addr});
        check({name, "_wrdata"}, {32'b0, wrdata_scan}, {32'b0, m_wrdata});
        check({name, "_we"}, {63'b0, we_scan}, {63'b0, m_we});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [65:0] f;
        logic [31:0] rb;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, FL,     1'b0, 1'b1};
        vecs[1] = '{1'b0, 32'hA5A5_0F0F, 32'h0000_0001, FL,     1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_1111, 32'h0000_2222, FL - 1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'hCAFE_0000, 32'h0000_0BAD, FL + 3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 0,      1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, FL,     1'b0, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0020, 32'h5555_AAAA, FL,     1'b1, !PAR};

        // Reset with both pads already high: release must not see an edge.
        scan_clk  = 1'b1;
        scan_load = 1'b1;
        tick(3);
        check_held("reset");
        check("reset_scan_out", {63'b0, scan_out}, 64'd0);
        check("reset_xfer", {63'b0, scanxfer_scan}, 64'd0);
        check("reset_pulses", {62'b0, sm_start_scan, frame_err}, 64'd0);
        rstn = 1'b1;
        tick(8);
        scan_clk  = 1'b0;
        scan_load = 1'b0;
        tick(4);
        check("no_phantom_shift", {63'b0, scanxfer_scan}, 64'd0);
        $display("reset released with pads high");

        for (int i = 0; i < 7; i++) begin
            f = make_frame(vecs[i].we, vecs[i].addr, vecs[i].wrdata, vecs[i].flip);
            shift_frame(f, vecs[i].nbits);
            if (vecs[i].nbits > 0) check("xfer_during_frame", {63'b0, scanxfer_scan}, 64'd1);
            if (vecs[i].exp_start) push_start(vecs[i].we, vecs[i].addr, vecs[i].wrdata);
            else                   push_err();
            pad_load();
            wait_drained("frame_pulse_seen");
            if (vecs[i].exp_start) begin
                m_addr = vecs[i].addr; m_wrdata = vecs[i].wrdata; m_we = vecs[i].we;
            end
            check_held("held");
            check("xfer_after_load", {63'b0, scanxfer_scan}, 64'd0);
            $display("vec %0d bits=%0d flip=%0d expect=%s", i, vecs[i].nbits, vecs[i].flip,
                     vecs[i].exp_start ? "start" : "err");
        end

        // Readback: rddata captured while idle, rdvalid ignored once shifting.
        rddata = 32'h1234_5678; rdvalid = 1'b1;
        tick(1);
        rdvalid = 1'b0; rddata = '0;
        tick(2);
        rb = '0;
        for (int k = 1; k <= FL; k++) begin
            pad_shift(1'b0);
            if (k == 2) begin
                rddata = 32'hFFFF_FFFF; rdvalid = 1'b1;
                tick(1);
                rdvalid = 1'b0; rddata = '0;
                tick(2);
            end
            if (k >= 33 && k <= 64) rb = {rb[30:0], scan_out};
        end
        check("readback_word", {32'b0, rb}, 64'h1234_5678);
        push_start(1'b0, 32'h0, 32'h0);
        pad_load();
        wait_drained("readback_commit");
        m_addr = '0; m_wrdata = '0; m_we = 1'b0;
        $display("readback word=0x%08h", rb);

        // Load and shift edges in the same cycle with a complete frame.
        f = make_frame(1'b1, 32'h0BEE_F000, 32'h1357_9BDF, 1'b0);
        shift_frame(f, FL);
        push_start(1'b1, 32'h0BEE_F000, 32'h1357_9BDF);
        scan_in = 1'b1; scan_clk = 1'b1; scan_load = 1'b1;
        tick(4);
        scan_clk = 1'b0; scan_load = 1'b0;
        tick(4);
        wait_drained("simul_commit");
        m_addr = 32'h0BEE_F000; m_wrdata = 32'h1357_9BDF; m_we = 1'b1;
        check("simul_shift_dropped", {63'b0, scanxfer_scan}, 64'd0);
        push_err();
        pad_load();
        wait_drained("simul_followup_err");
        $display("simultaneous load+shift committed");

        // Reset in the middle of a frame.
        f = make_frame(1'b1, 32'h7777_7777, 32'h8888_8888, 1'b0);
        shift_frame(f, 30);
        #3 rstn = 1'b0;
        tick(2);
        m_addr = '0; m_wrdata = '0; m_we = 1'b0;
        check_held("midreset");
        check("midreset_xfer", {63'b0, scanxfer_scan}, 64'd0);
        rstn = 1'b1;
        tick(8);
        check("midreset_no_pulse", 64'(sb_q.size()), 64'd0);
        push_err();
        pad_load();
        wait_drained("midreset_load_err");
        check_held("midreset_final");
        $display("mid-frame reset then load");

        tick(10);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
